// File: rtl/bitstream_buffer_pkg.sv
// Shared widths, limits and error coding for the bitstream window buffer.
// Imported by the buffer top and its shift/merge datapath.
package bitstream_buffer_pkg;

    localparam int WIN_W   = 16;
    localparam int BUF_W   = 32;
    localparam int COUNT_W = 6;

    localparam logic [COUNT_W-1:0] WIN_COUNT       = 6'd16;
    localparam logic [4:0]         MAX_CONSUME_LEN = 5'd16;

    // Sticky error meaning: the only recorded fault is an illegal consume request.
    typedef enum logic [0:0] {
        ERR_NONE            = 1'b0,
        ERR_ILLEGAL_CONSUME = 1'b1
    } err_code_t;

    function automatic logic consume_len_legal(input logic [4:0] len);
        return (len <= MAX_CONSUME_LEN);
    endfunction

endpackage

// File: rtl/bitstream_shift_merge.sv
// Combinational datapath: drop consumed bits off the top of the buffer and
// OR the incoming word in directly below the bits that remain.
module bitstream_shift_merge
    import bitstream_buffer_pkg::*;
(
    input  logic [BUF_W-1:0]   buf_cur,
    input  logic [COUNT_W-1:0] shift_len,
    input  logic [WIN_W-1:0]   word_in,
    input  logic [COUNT_W-1:0] fill_pos,
    input  logic               refill,
    output logic [BUF_W-1:0]   buf_next
);

    logic [BUF_W-1:0] shifted_s;
    logic [BUF_W-1:0] insert_s;

    // Left barrel shift plus right-shifted insert; zeros below the valid region keep the OR safe
    always_comb begin
        shifted_s = buf_cur << shift_len;
        insert_s  = {BUF_W{1'b0}};
        if (refill) begin
            insert_s = {word_in, {WIN_W{1'b0}}} >> fill_pos;
        end else begin
            insert_s = {BUF_W{1'b0}};
        end
        buf_next = shifted_s | insert_s;
    end

endmodule

// File: rtl/bitstream_buffer.sv
// Left-aligned 16-bit bitstream window for the syntax decoders: absorbs
// 16-bit RBSP words and retires up to 16 consumed bits every cycle.
module bitstream_buffer
    import bitstream_buffer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [15:0]      word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             consume_valid,
    input  logic [4:0]       consume_len,
    output logic [15:0]      BitStream_buffer_output,
    output logic             buffer_valid,
    output logic             byte_aligned,
    output logic [CNT_W-1:0] bits_consumed,
    output logic             err
);

    logic [BUF_W-1:0]   buf_r;
    logic [COUNT_W-1:0] count_r;
    logic [2:0]         phase_r;
    logic [CNT_W-1:0]   bits_consumed_r;
    err_code_t          err_r;

    logic [BUF_W-1:0]   buf_next_s;
    logic [COUNT_W-1:0] count_next_s;
    logic [COUNT_W-1:0] take_len_s;
    logic [COUNT_W-1:0] fill_pos_s;
    logic               buffer_valid_s;
    logic               word_ready_s;
    logic               take_s;
    logic               illegal_s;
    logic               refill_s;

    // Consume/refill decisions; readiness looks only at the registered fill level
    always_comb begin
        buffer_valid_s = 1'b0;
        word_ready_s   = 1'b0;
        take_s         = 1'b0;
        illegal_s      = 1'b0;
        take_len_s     = {COUNT_W{1'b0}};
        fill_pos_s     = {COUNT_W{1'b0}};
        refill_s       = 1'b0;
        count_next_s   = {COUNT_W{1'b0}};

        buffer_valid_s = (count_r >= WIN_COUNT);
        word_ready_s   = (count_r <= WIN_COUNT) && !flush;
        take_s         = consume_valid && buffer_valid_s && consume_len_legal(consume_len);
        illegal_s      = consume_valid && !take_s;
        if (take_s) begin
            take_len_s = {1'b0, consume_len};
        end else begin
            take_len_s = {COUNT_W{1'b0}};
        end
        // Fill level after the consume; the new word lands right below it
        fill_pos_s = count_r - take_len_s;
        refill_s   = word_valid && word_ready_s;
        if (refill_s) begin
            count_next_s = fill_pos_s + WIN_COUNT;
        end else begin
            count_next_s = fill_pos_s;
        end
    end

    bitstream_shift_merge u_shift_merge (
        .buf_cur   (buf_r),
        .shift_len (take_len_s),
        .word_in   (word_in),
        .fill_pos  (fill_pos_s),
        .refill    (refill_s),
        .buf_next  (buf_next_s)
    );

    // Buffer state; flush restarts at a byte-aligned NAL boundary but keeps the error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r           <= {BUF_W{1'b0}};
            count_r         <= {COUNT_W{1'b0}};
            phase_r         <= 3'd0;
            bits_consumed_r <= {CNT_W{1'b0}};
            err_r           <= ERR_NONE;
        end else if (flush) begin
            buf_r           <= {BUF_W{1'b0}};
            count_r         <= {COUNT_W{1'b0}};
            phase_r         <= 3'd0;
            bits_consumed_r <= {CNT_W{1'b0}};
            err_r           <= err_r;
        end else begin
            buf_r           <= buf_next_s;
            count_r         <= count_next_s;
            phase_r         <= phase_r + take_len_s[2:0];
            bits_consumed_r <= bits_consumed_r + CNT_W'(take_len_s);
            if (illegal_s) begin
                err_r <= ERR_ILLEGAL_CONSUME;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign BitStream_buffer_output = buf_r[BUF_W-1:BUF_W-WIN_W];
    assign buffer_valid            = buffer_valid_s;
    assign byte_aligned            = (phase_r == 3'd0);
    assign word_ready              = word_ready_s;
    assign bits_consumed           = bits_consumed_r;
    assign err                     = (err_r != ERR_NONE);

endmodule

// File: tb/tb_bitstream_buffer.sv
// Self-checking bench for bitstream_buffer: directed scenarios plus random
// traffic, compared against a bit-queue reference model.
module tb_bitstream_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] word_in = 16'h0000;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        consume_valid = 1'b0;
    logic [4:0]  consume_len = 5'd0;
    logic [15:0] BitStream_buffer_output;
    logic        buffer_valid;
    logic        byte_aligned;
    logic [31:0] bits_consumed;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the unconsumed bits in stream order
    bit          mq[$];
    logic [31:0] m_cons = 32'd0;
    bit          m_err = 1'b0;

    bitstream_buffer #(.CNT_W(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .flush                   (flush),
        .word_in                 (word_in),
        .word_valid              (word_valid),
        .word_ready              (word_ready),
        .consume_valid           (consume_valid),
        .consume_len             (consume_len),
        .BitStream_buffer_output (BitStream_buffer_output),
        .buffer_valid            (buffer_valid),
        .byte_aligned            (byte_aligned),
        .bits_consumed           (bits_consumed),
        .err                     (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
        end
    endtask

    function automatic logic [15:0] model_window();
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (i < mq.size()) w[15-i] = mq[i];
        end
        return w;
    endfunction

    task automatic compare_outputs();
        check_val("window", 32'(BitStream_buffer_output), 32'(model_window()));
        check_val("buffer_valid", 32'(buffer_valid), 32'(mq.size() >= 16));
        check_val("byte_aligned", 32'(byte_aligned), 32'(m_cons[2:0] == 3'd0));
        check_val("bits_consumed", bits_consumed, m_cons);
        check_val("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; word_valid = 1'b0; consume_valid = 1'b0;
        word_in = 16'h0000; consume_len = 5'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_cons = 32'd0;
        m_err  = 1'b0;
        #1;
        check_val("rst_window", 32'(BitStream_buffer_output), 32'h0);
        check_val("rst_buffer_valid", 32'(buffer_valid), 32'h0);
        check_val("rst_byte_aligned", 32'(byte_aligned), 32'h1);
        check_val("rst_bits_consumed", bits_consumed, 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        check_val("rst_word_ready", 32'(word_ready), 32'h1);
    endtask

    task automatic step(input logic fl, input logic wv, input logic [15:0] w,
                        input logic cv, input logic [4:0] cl);
        bit m_ready;
        bit legal;
        @(negedge clk);
        flush = fl; word_valid = wv; word_in = w; consume_valid = cv; consume_len = cl;
        m_ready = (mq.size() <= 16) && !fl;
        #1;
        check_val("word_ready", 32'(word_ready), 32'(m_ready));
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_cons = 32'd0;
        end else begin
            legal = cv && (mq.size() >= 16) && (cl <= 5'd16);
            if (cv && !legal) m_err = 1'b1;
            if (legal) begin
                for (int i = 0; i < int'(cl); i++) void'(mq.pop_front());
                m_cons = m_cons + 32'(cl);
            end
            if (wv && m_ready) begin
                for (int i = 15; i >= 0; i--) mq.push_back(w[i]);
            end
        end
        #1;
        compare_outputs();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        r_fl;
        logic        r_wv;
        logic        r_cv;
        logic [4:0]  r_cl;

        do_reset();

        // Fill to 32 bits, then nibble-sized consumes
        step(1'b0, 1'b1, 16'hA5C3, 1'b0, 5'd0);
        step(1'b0, 1'b1, 16'h0F0F, 1'b0, 5'd0);
        check_val("p1_window", 32'(BitStream_buffer_output), 32'hA5C3);
        check_val("p1_full_ready", 32'(word_ready), 32'h0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 5'd4);
        check_val("p2_window_a", 32'(BitStream_buffer_output), 32'h5C30);
        check_val("p2_unaligned", 32'(byte_aligned), 32'h0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 5'd4);
        check_val("p2_window_b", 32'(BitStream_buffer_output), 32'hC30F);

        // Full-rate streaming
        do_reset();
        step(1'b0, 1'b1, 16'h1234, 1'b0, 5'd0);
        check_val("p3_w0", 32'(BitStream_buffer_output), 32'h1234);
        step(1'b0, 1'b1, 16'h5678, 1'b1, 5'd16);
        check_val("p3_w1", 32'(BitStream_buffer_output), 32'h5678);
        step(1'b0, 1'b1, 16'h9ABC, 1'b1, 5'd16);
        check_val("p3_w2", 32'(BitStream_buffer_output), 32'h9ABC);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 5'd16);
        check_val("p3_consumed", bits_consumed, 32'd48);

        // Word rejected at count 20, then placed below 12 remaining bits
        do_reset();
        step(1'b0, 1'b1, 16'hA5C3, 1'b0, 5'd0);
        step(1'b0, 1'b1, 16'h0F0F, 1'b0, 5'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 5'd12);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 5'd8);
        check_val("p4_ready_after", 32'(word_ready), 32'h1);
        step(1'b0, 1'b1, 16'h6D2B, 1'b0, 5'd0);

        // Illegal consumes set a sticky error without side effects
        do_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b1, 5'd4);
        step(1'b0, 1'b1, 16'hA5C3, 1'b0, 5'd0);
        step(1'b0, 1'b1, 16'h0F0F, 1'b1, 5'd17);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 5'd8);

        // Flush at count 24 with a word offered
        step(1'b1, 1'b1, 16'h1111, 1'b1, 5'd4);
        check_val("p6_err_kept", 32'(err), 32'h1);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0, 5'd0);
        check_val("p6_window", 32'(BitStream_buffer_output), 32'hBEEF);

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r_fl = ($urandom_range(0, 39) == 0);
            r_wv = ($urandom_range(0, 9) < 7);
            r_cv = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) r_cl = 5'($urandom_range(17, 31));
            else r_cl = 5'($urandom_range(0, 16));
            step(r_fl, r_wv, 16'($urandom), r_cv, r_cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
